// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: owner-tag encoding and read-latency limits shared by the arbiter slice
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_I    = 2'd1,
      TAG_D    = 2'd2
   } tag_t;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction, data and shared memory port signals of the arbiter
interface mem_arbiter_if #(parameter int AW = 32);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [31:0]   i_rdata;
   logic          d_req;
   logic [3:0]    d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [31:0]   d_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_tagpipe.sv
// mem_arb_tagpipe: LAT-deep shift register carrying the owner of each memory access
module mem_arb_tagpipe
   import mem_arbiter_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t i_tag,
   output tag_t o_tag
);
   localparam int DEPTH = (LAT < LAT_MIN) ? LAT_MIN : (LAT > LAT_MAX) ? LAT_MAX : LAT;
   tag_t r_pipe [DEPTH];
   // shift the owner tag one stage per cycle; reset drops every in-flight read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) r_pipe[k] <= TAG_NONE;
      end else begin
         r_pipe[0] <= i_tag;
         for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end
   assign o_tag = r_pipe[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-over-instruction arbiter for one memory port; MEM_ARBITER_STARVE_EN adds the instruction-side starvation boost
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int LAT        = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   logic          w_boost;
   logic          w_i_gnt;
   logic          w_d_gnt;
   logic [AW-1:0] w_addr;
   tag_t          w_tag_in;
   tag_t          w_tag_out;
   logic          w_i_rv;
   logic          w_d_rv;
   logic [31:0]   r_i_rdata;
   logic [31:0]   r_d_rdata;
`ifdef MEM_ARBITER_STARVE_EN
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [CW-1:0] r_starve;
   // count consecutive cycles the instruction side waits, saturating at the boost threshold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_starve <= '0;
      else if (!bus.i_req || w_i_gnt) r_starve <= '0;
      else if (r_starve != CW'(STARVE_MAX)) r_starve <= r_starve + 1'b1;
   end
   assign w_boost = (r_starve == CW'(STARVE_MAX));
`else
   assign w_boost = 1'b0;
`endif
   assign w_i_gnt = rst && bus.i_req && (!bus.d_req || w_boost);
   assign w_d_gnt = rst && bus.d_req && !w_i_gnt;
   assign w_addr  = w_i_gnt ? bus.i_addr : bus.d_addr;
   // drive the shared memory port from whichever side won this cycle
   always_comb begin
      bus.i_gnt     = w_i_gnt;
      bus.d_gnt     = w_d_gnt;
      bus.mem_en    = w_i_gnt || w_d_gnt;
      bus.mem_we    = w_d_gnt ? bus.d_we : 4'b0000;
      bus.mem_addr  = w_addr;
      bus.mem_wdata = bus.d_wdata;
      w_tag_in      = w_i_gnt ? TAG_I : (w_d_gnt && bus.d_we == 4'b0000) ? TAG_D : TAG_NONE;
   end
   mem_arb_tagpipe #(.LAT(LAT)) u_tagpipe (
      .clk   (clk),
      .rst   (rst),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );
   assign w_i_rv = (w_tag_out == TAG_I);
   assign w_d_rv = (w_tag_out == TAG_D);
   // remember the last returned word per side so rdata holds between responses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_i_rv) r_i_rdata <= bus.mem_rdata;
         if (w_d_rv) r_d_rdata <= bus.mem_rdata;
      end
   end
   assign bus.i_rvalid = w_i_rv;
   assign bus.d_rvalid = w_d_rv;
   assign bus.i_rdata  = w_i_rv ? bus.mem_rdata : r_i_rdata;
   assign bus.d_rdata  = w_d_rv ? bus.mem_rdata : r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of two arbiters (LAT=1, LAT=3) against a history-based model
module tb_mem_arbiter;
   localparam int SMAX = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic        d_req = 1'b0;
   logic [3:0]  d_we = 4'd0;
   logic [31:0] i_addr = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] mem_rdata = '0;
   int n_vec = 0;
   int n_err = 0;
   int cnt = 0;
   int hist[$];
   logic [31:0] last_i[2];
   logic [31:0] last_d[2];

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(32)) b1 ();
   mem_arbiter_if #(.AW(32)) b3 ();
   assign b1.i_req = i_req;
   assign b1.i_addr = i_addr;
   assign b1.d_req = d_req;
   assign b1.d_we = d_we;
   assign b1.d_addr = d_addr;
   assign b1.d_wdata = d_wdata;
   assign b1.mem_rdata = mem_rdata;
   assign b3.i_req = i_req;
   assign b3.i_addr = i_addr;
   assign b3.d_req = d_req;
   assign b3.d_we = d_we;
   assign b3.d_addr = d_addr;
   assign b3.d_wdata = d_wdata;
   assign b3.mem_rdata = mem_rdata;

   mem_arbiter #(.AW(32), .LAT(1), .STARVE_MAX(SMAX)) u1 (.clk(clk), .rst(rst), .bus(b1));
   mem_arbiter #(.AW(32), .LAT(3), .STARVE_MAX(SMAX)) u3 (.clk(clk), .rst(rst), .bus(b3));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int emerge(input int l);
      return (hist.size() >= l) ? hist[l-1] : 0;
   endfunction

   task automatic cmp(input string s, input logic ig, input logic dg, input logic me,
                      input logic [3:0] mw, input logic [31:0] ma, input logic [31:0] mwd,
                      input logic iv, input logic dv, input logic [31:0] ir, input logic [31:0] dr,
                      input logic eg, input logic edg, input int em,
                      input logic [31:0] li, input logic [31:0] ld);
      chk({s, ".i_gnt"}, ig, eg);
      chk({s, ".d_gnt"}, dg, edg);
      chk({s, ".mem_en"}, me, eg | edg);
      chk({s, ".mem_we"}, mw, edg ? d_we : 4'd0);
      if (eg) chk({s, ".mem_addr_i"}, ma, i_addr);
      if (edg) chk({s, ".mem_addr_d"}, ma, d_addr);
      if (edg && d_we != 0) chk({s, ".mem_wdata"}, mwd, d_wdata);
      chk({s, ".i_rvalid"}, iv, em == 1);
      chk({s, ".d_rvalid"}, dv, em == 2);
      chk({s, ".i_rdata"}, ir, (em == 1) ? mem_rdata : li);
      chk({s, ".d_rdata"}, dr, (em == 2) ? mem_rdata : ld);
   endtask

   // reference model: grants from priority rules, returns from a per-cycle tag history
   always @(negedge clk) begin : model
      logic boost, eg, edg;
      int tag, e1, e3;
      if (!rst) begin
         cnt = 0;
         hist = {};
         last_i = '{2{32'd0}};
         last_d = '{2{32'd0}};
      end
      boost = 1'b0;
`ifdef MEM_ARBITER_STARVE_EN
      boost = (cnt == SMAX);
`endif
      eg = rst && i_req && (!d_req || boost);
      edg = rst && d_req && !eg;
      tag = eg ? 1 : (edg && d_we == 4'd0) ? 2 : 0;
      e1 = emerge(1);
      e3 = emerge(3);
      cmp("lat1", b1.i_gnt, b1.d_gnt, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata,
          b1.i_rvalid, b1.d_rvalid, b1.i_rdata, b1.d_rdata, eg, edg, e1, last_i[0], last_d[0]);
      cmp("lat3", b3.i_gnt, b3.d_gnt, b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata,
          b3.i_rvalid, b3.d_rvalid, b3.i_rdata, b3.d_rdata, eg, edg, e3, last_i[1], last_d[1]);
      if (rst) begin
         if (e1 == 1) last_i[0] = mem_rdata;
         if (e1 == 2) last_d[0] = mem_rdata;
         if (e3 == 1) last_i[1] = mem_rdata;
         if (e3 == 2) last_d[1] = mem_rdata;
         cnt = (!i_req || eg) ? 0 : (cnt < SMAX) ? cnt + 1 : cnt;
         hist.push_front(tag);
         if (hist.size() > 4) void'(hist.pop_back());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_i;
      cyc();
      cyc();
      #2;
      chk("rst_i_rvalid", b3.i_rvalid, 1'b0);
      chk("rst_i_rdata", b3.i_rdata, 32'd0);
      chk("rst_mem_en", b1.mem_en, 1'b0);
      cyc();
      rst = 1'b1;
      i_req = 1'b1;
      i_addr = 32'h40;
      #2;
      chk("t034_i_gnt", b1.i_gnt, 1'b1);
      chk("t034_mem_addr", b1.mem_addr, 32'h40);
      cyc();
      i_req = 1'b0;
      mem_rdata = 32'h2402000A;
      #2;
      chk("t034_i_rvalid", b1.i_rvalid, 1'b1);
      chk("t034_i_rdata", b1.i_rdata, 32'h2402000A);
      cyc();
      mem_rdata = 32'h11111111;
      #2;
      chk("t034_rvalid_pulse", b1.i_rvalid, 1'b0);
      chk("t034_rdata_hold", b1.i_rdata, 32'h2402000A);
      cyc();
      i_req = 1'b1;
      d_req = 1'b1;
      d_we = 4'd0;
      d_addr = 32'h80;
      #2;
      chk("t035_d_gnt", b1.d_gnt, 1'b1);
      chk("t035_i_gnt", b1.i_gnt, 1'b0);
      cyc();
      d_req = 1'b0;
      #2;
      chk("t035_i_gnt_next", b1.i_gnt, 1'b1);
      cyc();
      i_req = 1'b0;
      d_req = 1'b1;
      d_we = 4'b0011;
      d_wdata = 32'h0000BEEF;
      #2;
      chk("t038_mem_we", b1.mem_we, 4'b0011);
      chk("t038_d_gnt", b1.d_gnt, 1'b1);
      chk("t038_wdata", b1.mem_wdata, 32'h0000BEEF);
      cyc();
      d_we = 4'd0;
      i_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         exp_i = 1'b0;
`ifdef MEM_ARBITER_STARVE_EN
         exp_i = (c == 5);
`endif
         #2;
         chk("t036_i_gnt", b1.i_gnt, exp_i);
         chk("t036_d_gnt", b1.d_gnt, !exp_i);
         cyc();
      end
      i_req = 1'b0;
      d_req = 1'b0;
      cyc();
      i_req = 1'b1;
      cyc();
      i_req = 1'b0;
      d_req = 1'b1;
      cyc();
      d_req = 1'b0;
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk("t039_no_rvalid", b3.i_rvalid | b3.d_rvalid, 1'b0);
         cyc();
      end
      i_req = 1'b1;
      cyc();
      i_req = 1'b0;
      cyc();
      cyc();
      mem_rdata = 32'hCAFE0001;
      #2;
      chk("t039_new_rvalid", b3.i_rvalid, 1'b1);
      chk("t039_new_rdata", b3.i_rdata, 32'hCAFE0001);
      repeat (3000) begin
         cyc();
         rst = ($urandom_range(0, 299) != 0);
         i_req = ($urandom_range(0, 9) < 7);
         d_req = ($urandom_range(0, 9) < 8);
         d_we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         i_addr = $urandom;
         d_addr = $urandom;
         d_wdata = $urandom;
         mem_rdata = $urandom;
      end
      cyc();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
